// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: combinational round-robin grant with
// per-requester bus lock, and a one-cycle read response routed to the owner.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic                  m0_we,
  input  logic [DATA_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [MASK_WIDTH-1:0] m0_mask,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic                  m1_we,
  input  logic [DATA_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [MASK_WIDTH-1:0] m1_mask,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [MASK_WIDTH-1:0] mem_mask,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_grant;
  logic   rsp_pending;
  logic   rsp_owner;
  logic   g0, g1;
  logic   read_gnt;

  always_comb begin
    g0      = 1'b0;
    g1      = 1'b0;
    state_d = state_q;
    // Reset level gates the grant so nothing reaches memory while held in reset.
    if (arst_n) begin
      case (state_q)
        IDLE: begin
          if (m0_req && (!m1_req || last_grant)) g0 = 1'b1;
          else if (m1_req)                       g1 = 1'b1;
          if (g0 && m0_lock)      state_d = LOCK0;
          else if (g1 && m1_lock) state_d = LOCK1;
        end
        LOCK0: begin
          g0 = m0_req;
          if (!m0_req || !m0_lock) state_d = IDLE;
        end
        LOCK1: begin
          g1 = m1_req;
          if (!m1_req || !m1_lock) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign mem_en    = g0 | g1;
  assign mem_we    = g0 ? m0_we   : (g1 ? m1_we   : 1'b0);
  assign mem_mask  = g0 ? m0_mask : (g1 ? m1_mask : '0);
  assign mem_addr  = g1 ? m1_addr  : m0_addr;
  assign mem_wdata = g1 ? m1_wdata : m0_wdata;
  assign read_gnt  = mem_en & ~mem_we;

  assign m0_rvalid = arst_n & rsp_pending & ~rsp_owner;
  assign m1_rvalid = arst_n & rsp_pending &  rsp_owner;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      last_grant  <= 1'b1;
      rsp_pending <= 1'b0;
      rsp_owner   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_pending <= read_gnt;
      if (mem_en)   last_grant <= g1;
      if (read_gnt) rsp_owner  <= g1;
    end
  end

endmodule
